pairing_result_unloader: RTL

Output-side companion to the `duursma_lee_algo` pairing core. It watches the core's `done` strobe and captures the 1163-bit `out` result into a shadow register on each rising edge of `done`. It then streams the captured result to a narrow consumer as 37 32-bit words, least-significant word first, over a valid/ready handshake. Results that arrive while a transfer is in progress are dropped and flagged.

---
 rtl/pairing_result_unloader.sv | 57 +++++
 1 files changed

// File: rtl/pairing_result_unloader.sv
// pairing_result_unloader: captures a pairing result on done rising edge and streams it out LSW-first
module pairing_result_unloader #(
   parameter int RES_W     = 1163,
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = (RES_W + WORD_W - 1) / WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              done,
   input  logic [RES_W-1:0]  res,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [WORD_W-1:0] word_data,
   output logic [5:0]        word_idx,
   output logic              word_last,
   output logic              busy,
   output logic              overrun
);
   typedef enum logic {IDLE, SEND} state_t;
   localparam int SW = NUM_WORDS * WORD_W;
   localparam logic [5:0] LAST = 6'(NUM_WORDS - 1);
   state_t state, state_n;
   logic [NUM_WORDS-1:0][WORD_W-1:0] shadow;
   logic [5:0] idx, idx_n;
   logic done_q, cap, hs, fin, load;
   assign cap  = done & ~done_q;
   assign hs   = (state == SEND) & word_ready;
   assign fin  = hs & (idx == LAST);
   // a capture coinciding with the final handshake chains straight into the next transfer
   assign load = cap & ((state == IDLE) | fin);
   always_comb begin
      state_n = state;
      idx_n   = idx;
      state_n = load ? SEND : fin ? IDLE : state;
      idx_n   = (load | fin) ? 6'd0 : hs ? idx + 6'd1 : idx;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         idx     <= '0;
         shadow  <= '0;
         done_q  <= 1'b1;
         overrun <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         done_q <= done;
         if (load) shadow <= SW'(res);
         if (cap & (state == SEND) & ~fin) overrun <= 1'b1;
      end
   end
   assign word_valid = state == SEND;
   assign busy       = state == SEND;
   assign word_idx   = idx;
   assign word_data  = shadow[idx];
   assign word_last  = word_valid & (idx == LAST);
endmodule
